// File: rtl/timeout_scanner.sv
// Per-flow retransmit deadline table with a round-robin scanner that reports expired flows.
// Optional macro TIMEOUT_EXP_BACKOFF_EN adds a per-flow 2-bit exponential backoff on the timer amount.
module timeout_scanner #(
  parameter int FLOW_CNT  = 16,
  parameter int FLOW_ID_W = 4,
  parameter int TIME_W    = 32,
  parameter int TIMER_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIME_W-1:0]    now,
  input  logic                 set_valid,
  input  logic [FLOW_ID_W-1:0] set_fid,
  input  logic [TIMER_W-1:0]   set_amnt,
  input  logic                 clr_valid,
  input  logic [FLOW_ID_W-1:0] clr_fid,
  output logic                 to_valid,
  input  logic                 to_ready,
  output logic [FLOW_ID_W-1:0] to_fid,
  output logic [TIME_W-1:0]    to_now
);

  // Timeout handshake: to_valid is raised once per detected event and held, with
  // to_fid/to_now stable, until the cycle where to_valid && to_ready transfers it.
  typedef enum logic {SCAN, EMIT} state_t;

  state_t               state;
  logic [FLOW_ID_W-1:0] ptr;
  logic [FLOW_CNT-1:0]  armed;
  logic [TIME_W-1:0]    deadline [FLOW_CNT];
  logic [TIME_W-1:0]    set_amt_eff;
  logic [TIME_W-1:0]    set_deadline;
  logic [TIME_W-1:0]    ptr_diff;
  logic                 ptr_hit;
  logic                 handshake;

`ifdef TIMEOUT_EXP_BACKOFF_EN
  logic [1:0]           backoff [FLOW_CNT];
  logic [TIMER_W+2:0]   amt_shifted;

  assign amt_shifted = {3'b000, set_amnt} << backoff[set_fid];
  assign set_amt_eff = TIME_W'(amt_shifted);
`else
  assign set_amt_eff = TIME_W'(set_amnt);
`endif

  assign set_deadline = now + set_amt_eff;

  // Wrap-safe compare: expired when now is at or past the deadline within half the time range.
  assign ptr_diff  = now - deadline[ptr];
  assign ptr_hit   = armed[ptr] && !ptr_diff[TIME_W-1]
                     && !(set_valid && set_fid == ptr)
                     && !(clr_valid && clr_fid == ptr);
  assign handshake = (state == EMIT) && to_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SCAN;
      ptr      <= '0;
      armed    <= '0;
      to_valid <= 1'b0;
      to_fid   <= '0;
      to_now   <= '0;
      for (int i = 0; i < FLOW_CNT; i++) deadline[i] <= '0;
    end else begin
      case (state)
        SCAN: begin
          ptr <= ptr + 1'b1;
          if (ptr_hit) begin
            to_fid   <= ptr;
            to_now   <= now;
            to_valid <= 1'b1;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (to_ready) begin
            to_valid <= 1'b0;
            ptr      <= to_fid + 1'b1;
            state    <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
      // Later assignments win: handshake disarm, then clear, then set.
      if (handshake) armed[to_fid] <= 1'b0;
      if (clr_valid) armed[clr_fid] <= 1'b0;
      if (set_valid) begin
        armed[set_fid]    <= 1'b1;
        deadline[set_fid] <= set_deadline;
      end
    end
  end

`ifdef TIMEOUT_EXP_BACKOFF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FLOW_CNT; i++) backoff[i] <= 2'd0;
    end else begin
      if (handshake && backoff[to_fid] != 2'd3) backoff[to_fid] <= backoff[to_fid] + 2'd1;
      if (clr_valid) backoff[clr_fid] <= 2'd0;
    end
  end
`endif

endmodule

// File: tb/tb_timeout_scanner.sv
// Directed and randomized checks of timeout_scanner against a per-cycle behavioural model.
// Build with or without TIMEOUT_EXP_BACKOFF_EN; the model follows the same macro.
module tb_timeout_scanner;

  localparam int FLOW_CNT = 16;

  logic        clk;
  logic        rst_n;
  logic [31:0] now;
  logic        set_valid;
  logic [3:0]  set_fid;
  logic [15:0] set_amnt;
  logic        clr_valid;
  logic [3:0]  clr_fid;
  logic        to_valid;
  logic        to_ready;
  logic [3:0]  to_fid;
  logic [31:0] to_now;

  timeout_scanner dut (
    .clk(clk), .rst_n(rst_n), .now(now),
    .set_valid(set_valid), .set_fid(set_fid), .set_amnt(set_amnt),
    .clr_valid(clr_valid), .clr_fid(clr_fid),
    .to_valid(to_valid), .to_ready(to_ready), .to_fid(to_fid), .to_now(to_now)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit          m_armed [FLOW_CNT];
  logic [31:0] m_dl    [FLOW_CNT];
  int          m_exp   [FLOW_CNT];
  int          m_ptr;
  bit          m_pend;
  int          m_fid;
  logic [31:0] m_now;
  logic [3:0]  exp_q [$];

  // Handshakes observed on the DUT outputs.
  logic [3:0]  ev_fid [$];
  logic [31:0] ev_now [$];

  task automatic model_reset();
    for (int i = 0; i < FLOW_CNT; i++) begin
      m_armed[i] = 0;
      m_dl[i]    = '0;
      m_exp[i]   = 0;
    end
    m_ptr  = 0;
    m_pend = 0;
    m_fid  = 0;
    m_now  = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic [31:0] eff;
    logic [31:0] age;
    bit          hs;
    int          hf;
    hs  = 0;
    hf  = 0;
    eff = 32'(set_amnt) * (32'd1 << m_exp[set_fid]);
    if (!m_pend) begin
      age = now - m_dl[m_ptr];
      if (m_armed[m_ptr] && age < 32'h8000_0000
          && !(set_valid && set_fid == 4'(m_ptr))
          && !(clr_valid && clr_fid == 4'(m_ptr))) begin
        m_pend = 1;
        m_fid  = m_ptr;
        m_now  = now;
      end
      m_ptr = (m_ptr + 1) % FLOW_CNT;
    end else if (to_ready) begin
      hs     = 1;
      hf     = m_fid;
      m_pend = 0;
      m_ptr  = (m_fid + 1) % FLOW_CNT;
      exp_q.push_back(4'(m_fid));
    end
    if (hs) begin
      m_armed[hf] = 0;
`ifdef TIMEOUT_EXP_BACKOFF_EN
      if (m_exp[hf] < 3) m_exp[hf]++;
`endif
    end
    if (clr_valid) begin
      m_armed[clr_fid] = 0;
      m_exp[clr_fid]   = 0;
    end
    if (set_valid) begin
      m_armed[set_fid] = 1;
      m_dl[set_fid]    = now + eff;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic chk_true(input string tag, input bit cond, input logic [31:0] got);
    n_cmp++;
    assert (cond) else begin
      n_bad++;
      $error("FAIL %s: observed %0h outside expected range", tag, got);
    end
  endtask

  // One clock: called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [3:0] exp_fid;
    bit         dut_hs;
    dut_hs = (to_valid === 1'b1) && to_ready;
    if (dut_hs) begin
      ev_fid.push_back(to_fid);
      ev_now.push_back(to_now);
    end
    @(posedge clk);
    model_edge();
    if (dut_hs) begin
      exp_fid = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      chk("handshake_fid", {28'd0, to_fid}, {28'd0, exp_fid});
    end
    @(negedge clk);
    chk("to_valid", {31'd0, to_valid}, {31'd0, m_pend});
    if (m_pend) begin
      chk("to_fid", {28'd0, to_fid}, 32'(m_fid));
      chk("to_now", to_now, m_now);
    end
    now = now + 1;
  endtask

  task automatic do_set(input int fid, input int amnt);
    set_valid = 1'b1;
    set_fid   = 4'(fid);
    set_amnt  = 16'(amnt);
    step();
    set_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int k;
    k = 0;
    while (to_valid !== 1'b1 && k < max_cyc) begin
      step();
      k++;
    end
    chk(tag, {31'd0, to_valid}, 32'd1);
  endtask

  initial begin
    int          k;
    logic [31:0] dl_exp;

    rst_n     = 1'b0;
    now       = '0;
    set_valid = 1'b0;
    set_fid   = '0;
    set_amnt  = '0;
    clr_valid = 1'b0;
    clr_fid   = '0;
    to_ready  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_to_valid", {31'd0, to_valid}, 32'd0);
    chk("rst_to_fid", {28'd0, to_fid}, 32'd0);
    chk("rst_to_now", to_now, 32'd0);
    rst_n = 1'b1;
    repeat (4) step();

    // Basic expiry: fid 3, amount 10 at now=100.
    now = 32'd100;
    do_set(3, 10);
    while (now <= 32'd110) begin
      chk("s1_quiet", {31'd0, to_valid}, 32'd0);
      step();
    end
    ev_fid.delete(); ev_now.delete();
    repeat (FLOW_CNT + 2) step();
    chk("s1_count", 32'(ev_fid.size()), 32'd1);
    chk("s1_fid", {28'd0, ev_fid[0]}, 32'd3);
    chk_true("s1_now", ev_now[0] >= 32'd110 && ev_now[0] <= 32'd110 + FLOW_CNT, ev_now[0]);
    ev_fid.delete(); ev_now.delete();
    repeat (3 * FLOW_CNT) step();
    chk("s1_disarmed", 32'(ev_fid.size()), 32'd0);

    // Wrap: deadline lands at 4 after the time base rolls over.
    now = 32'hFFFF_FFF0;
    do_set(5, 20);
    ev_fid.delete(); ev_now.delete();
    while (now != 32'd5) begin
      chk("s2_quiet", {31'd0, to_valid}, 32'd0);
      step();
    end
    chk("s2_no_early", 32'(ev_fid.size()), 32'd0);
    repeat (FLOW_CNT + 2) step();
    chk("s2_count", 32'(ev_fid.size()), 32'd1);
    chk("s2_fid", {28'd0, ev_fid[0]}, 32'd5);
    chk_true("s2_now", ev_now[0] >= 32'd4 && ev_now[0] <= 32'd4 + FLOW_CNT, ev_now[0]);

    // Backpressure: fids 1 and 2 share a deadline reached while the scanner sits at 3.
    to_ready = 1'b0;
    k = ((3 - m_ptr + FLOW_CNT) % FLOW_CNT) + FLOW_CNT;
    do_set(1, k);
    do_set(2, k - 1);
    wait_valid(4 * FLOW_CNT, "s3_valid");
    for (int i = 0; i < 8; i++) begin
      chk("s3_hold_valid", {31'd0, to_valid}, 32'd1);
      chk("s3_hold_fid", {28'd0, to_fid}, 32'd1);
      step();
    end
    to_ready = 1'b1;
    step();
    to_ready = 1'b0;
    wait_valid(2 * FLOW_CNT, "s3_second_valid");
    chk("s3_second_fid", {28'd0, to_fid}, 32'd2);
    to_ready = 1'b1;
    step();

    // Race: clear fid 7 while its event is pending.
    to_ready = 1'b0;
    do_set(7, 1);
    wait_valid(3 * FLOW_CNT, "s4_valid");
    chk("s4_fid", {28'd0, to_fid}, 32'd7);
    clr_valid = 1'b1;
    clr_fid   = 4'd7;
    step();
    clr_valid = 1'b0;
    chk("s4_kept_valid", {31'd0, to_valid}, 32'd1);
    chk("s4_kept_fid", {28'd0, to_fid}, 32'd7);
    to_ready = 1'b1;
    ev_fid.delete(); ev_now.delete();
    repeat (3 * FLOW_CNT) step();
    chk("s4_once", 32'(ev_fid.size()), 32'd1);
    chk("s4_once_fid", {28'd0, ev_fid[0]}, 32'd7);
    set_valid = 1'b1; set_fid = 4'd7; set_amnt = 16'd3;
    clr_valid = 1'b1; clr_fid = 4'd7;
    step();
    set_valid = 1'b0;
    clr_valid = 1'b0;
    ev_fid.delete(); ev_now.delete();
    repeat (40) step();
    chk("s4_set_wins", 32'(ev_fid.size()), 32'd1);
    chk("s4_set_wins_fid", {28'd0, ev_fid[0]}, 32'd7);

    // Reset mid-EMIT drops the pending event.
    to_ready = 1'b0;
    do_set(9, 2);
    wait_valid(3 * FLOW_CNT, "s5_valid");
    rst_n = 1'b0;
    #1;
    chk("s5_async_drop", {31'd0, to_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    to_ready = 1'b1;
    ev_fid.delete(); ev_now.delete();
    repeat (3 * FLOW_CNT) step();
    chk("s5_silent", 32'(ev_fid.size()), 32'd0);
    do_set(4, 2);
    ev_fid.delete(); ev_now.delete();
    repeat (FLOW_CNT + 4) step();
    chk("s5_new_count", 32'(ev_fid.size()), 32'd1);
    chk("s5_new_fid", {28'd0, ev_fid[0]}, 32'd4);

    // Two timeouts on fid 0, then amount 10 at now=0.
    repeat (2) begin
      do_set(0, 1);
      ev_fid.delete(); ev_now.delete();
      repeat (FLOW_CNT + 6) step();
      chk("s6_pre_count", 32'(ev_fid.size()), 32'd1);
      chk("s6_pre_fid", {28'd0, ev_fid[0]}, 32'd0);
    end
`ifdef TIMEOUT_EXP_BACKOFF_EN
    dl_exp = 32'd40;
`else
    dl_exp = 32'd10;
`endif
    now = 32'd0;
    do_set(0, 10);
    while (now <= dl_exp) begin
      chk("s6_quiet", {31'd0, to_valid}, 32'd0);
      step();
    end
    ev_fid.delete(); ev_now.delete();
    repeat (FLOW_CNT + 3) step();
    chk("s6_count", 32'(ev_fid.size()), 32'd1);
    chk("s6_fid", {28'd0, ev_fid[0]}, 32'd0);
    chk_true("s6_now", ev_now[0] >= dl_exp && ev_now[0] <= dl_exp + FLOW_CNT, ev_now[0]);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      set_valid = ($urandom_range(0, 3) == 0);
      set_fid   = 4'($urandom_range(0, FLOW_CNT - 1));
      set_amnt  = 16'($urandom_range(0, 40));
      clr_valid = ($urandom_range(0, 5) == 0);
      clr_fid   = 4'($urandom_range(0, FLOW_CNT - 1));
      to_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    set_valid = 1'b0;
    clr_valid = 1'b0;
    to_ready  = 1'b1;
    repeat (400) step();
    chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timeout_scanner.md
TIMEOUT_SCANNER -- requirements
Module: timeout_scanner

Interface
REQ-001 Parameter FLOW_CNT, 16, number of flows tracked; power of two, minimum 2.
REQ-002 Parameter FLOW_ID_W, 4, flow id width = log2(FLOW_CNT).
REQ-003 Parameter TIME_W, 32, width of the time base and of the stored deadlines.
REQ-004 Parameter TIMER_W, 16, width of a retransmit timer amount.
REQ-005 Ports (name  direction  width  meaning), clock and reset first:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- now  in  TIME_W  free-running global time; wraps modulo 2^TIME_W.
- set_valid  in  1  arm or re-arm the timer of set_fid.
- set_fid  in  FLOW_ID_W  flow to arm.
- set_amnt  in  TIMER_W  timer amount; deadline = now + amount.
- clr_valid  in  1  disarm the timer of clr_fid (flow fully acked).
- clr_fid  in  FLOW_ID_W  flow to disarm.
- to_valid  out  1  timeout event presented.
- to_ready  in  1  downstream timeout-handling stage accepts the event.
- to_fid  out  FLOW_ID_W  flow whose timer expired.
- to_now  out  TIME_W  value of now when the expiry was detected.

Function
REQ-006 Per-flow state: armed bit and TIME_W deadline, held in registers (FLOW_CNT entries).
REQ-007 Set: at the clock edge with set_valid=1, deadline[set_fid] <= now + zero-extended effective amount (mod 2^TIME_W) and armed[set_fid] <= 1.
REQ-008 Clear: at the clock edge with clr_valid=1, armed[clr_fid] <= 0; deadline is unchanged.
REQ-009 Set and clear on the same fid in the same cycle: set wins. Set and clear on different fids in the same cycle: both take effect.
REQ-010 Expiry test: an entry is expired when it is armed and (now - deadline) mod 2^TIME_W has MSB 0, i.e. now >= deadline under wrap-around. Deadline == now counts as expired.
REQ-011 FSM states:
- SCAN: ptr advances by 1 each cycle, wrapping FLOW_CNT-1 -> 0. If entry ptr is expired and is not being set or cleared this cycle, latch to_fid <= ptr and to_now <= now, and go to EMIT.
- EMIT: to_valid=1. to_fid and to_now hold stable until to_valid && to_ready. On the handshake, disarm the entry (unless set_valid hits that fid in the same cycle, in which case the set wins), ptr <= to_fid+1, and return to SCAN.
REQ-012 In EMIT, to_valid is not withdrawn even if the entry is cleared or re-armed before the handshake; the event is still delivered.
REQ-013 Latency: a flow that becomes expired is detected within FLOW_CNT cycles in SCAN. to_valid asserts the cycle after detection.
REQ-014 Set and clear are accepted in every state, with no backpressure.
REQ-015 to_valid is a registered output; it is 0 in SCAN.

Reset
REQ-016 On rst_n low, asynchronously: state=SCAN, ptr=0, all armed=0, deadlines=0, to_valid=0, to_fid=0, to_now=0, and all backoff exponents=0.
REQ-017 Reset asserted mid-EMIT drops the pending event. After release, no event is produced until a new set occurs.

Configuration
REQ-018 Macro TIMEOUT_EXP_BACKOFF_EN.
- Defined: each flow keeps a 2-bit exponent e. The effective amount is set_amnt << e, computed at TIMER_W+3 bits. e increments, saturating at 3, on each timeout handshake for that flow, and resets to 0 on clr_valid for that flow.
- Not defined: no exponent storage, and the effective amount is set_amnt.

Verification
REQ-019 Basic expiry: set fid 3, amnt 10 at now=100; now increments by 1 per cycle. -> No event before now=110. to_valid with to_fid=3 and to_now in 110..110+FLOW_CNT, then armed[3]=0 after the handshake.
REQ-020 Wrap: set fid 5, amnt 20 at now=0xFFFF_FFF0. -> The event fires once now reaches 0x0000_0004, not at set time.
REQ-021 Backpressure: fids 1 and 2 expire together with to_ready=0 for 8 cycles. -> to_fid=1 is held stable for 8 cycles. After the handshake, fid 2 is reported next.
REQ-022 Race: at detection of fid 7, clear fid 7 while to_valid=1. -> The event is still delivered once, and no second event follows. Same-cycle set and clear on fid 7 leaves it armed.
REQ-023 Reset: rst_n pulsed low mid-EMIT. -> to_valid drops immediately, and no event occurs afterwards without a new set.
REQ-024 With TIMEOUT_EXP_BACKOFF_EN: after two timeouts on fid 0, set amnt 10 at now=0. -> Expiry occurs at now=40. Without the macro, expiry occurs at now=10.
